// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multicycle controller (mc_ctrl, mc_decode)
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0100;

    localparam logic [2:0] NPC_PC4    = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JAL    = 3'b010;
    localparam logic [2:0] NPC_JR     = 3'b011;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    // Bit positions in the one-hot instruction vector from mc_decode
    localparam int I_ADD   = 0;
    localparam int I_SUB   = 1;
    localparam int I_ORI   = 2;
    localparam int I_LW    = 3;
    localparam int I_SW    = 4;
    localparam int I_BEQ   = 5;
    localparam int I_LUI   = 6;
    localparam int I_ADDIU = 7;
    localparam int I_JAL   = 8;
    localparam int I_JR    = 9;
    localparam int NUM_INSTR = 10;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - opcode/funct to one-hot instruction class plus illegal flag
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]           opcode_i,
    input  logic [5:0]           funct_i,
    output logic [NUM_INSTR-1:0] instr_o,
    output logic                 illegal_o
);

    // Pure table lookup; anything that matches no row is illegal
    always_comb begin
        instr_o = '0;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD:  instr_o[I_ADD] = 1'b1;
                    FN_SUB:  instr_o[I_SUB] = 1'b1;
                    FN_JR:   instr_o[I_JR]  = 1'b1;
                    default: instr_o        = '0;
                endcase
            end
            OP_ORI:   instr_o[I_ORI]   = 1'b1;
            OP_LW:    instr_o[I_LW]    = 1'b1;
            OP_SW:    instr_o[I_SW]    = 1'b1;
            OP_BEQ:   instr_o[I_BEQ]   = 1'b1;
            OP_LUI:   instr_o[I_LUI]   = 1'b1;
            OP_ADDIU: instr_o[I_ADDIU] = 1'b1;
            OP_JAL:   instr_o[I_JAL]   = 1'b1;
            default:  instr_o          = '0;
        endcase
    end

    assign illegal_o = (instr_o == '0);

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle CPU control FSM with optional perf counters (MC_CTRL_PERF_EN)
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic        alu_src,
    output logic [1:0]  mem_to_reg,
    output logic        ext_op,
    output logic [3:0]  alu_op,
    output logic [2:0]  npc_op,
    output logic [2:0]  state,
    output logic        trap,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    state_e               state_q, state_d;
    logic [NUM_INSTR-1:0] instr;
    logic                 illegal;

    // The IR fields are stable from DECODE onwards, so decode is left combinational
    mc_decode u_decode (
        .opcode_i  (opcode),
        .funct_i   (funct),
        .instr_o   (instr),
        .illegal_o (illegal)
    );

    // State register; reset forces FETCH without waiting for a clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_FETCH;
        else          state_q <= state_d;
    end

    // Next state and Moore/Mealy outputs; everything idles at 0 unless a state drives it
    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = RD_RT;
        alu_src    = 1'b0;
        mem_to_reg = WD_ALU;
        ext_op     = 1'b0;
        alu_op     = ALU_ADD;
        npc_op     = NPC_PC4;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = illegal ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                alu_src = instr[I_ORI] | instr[I_LW] | instr[I_SW] | instr[I_LUI] | instr[I_ADDIU];
                ext_op  = instr[I_LW] | instr[I_SW] | instr[I_ADDIU];
                if (instr[I_SUB] | instr[I_BEQ]) alu_op = ALU_SUB;
                else if (instr[I_ORI])           alu_op = ALU_OR;
                else if (instr[I_LUI])           alu_op = ALU_LUI;
                if (instr[I_LW] | instr[I_SW])                      state_d = ST_MEM;
                else if (instr[I_BEQ] | instr[I_JAL] | instr[I_JR]) state_d = ST_FETCH;
                else                                                state_d = ST_WB;
                if (instr[I_BEQ]) begin
                    npc_op = NPC_BRANCH;
                    pc_we  = zero;
                end
                if (instr[I_JAL]) begin
                    npc_op     = NPC_JAL;
                    pc_we      = 1'b1;
                    reg_we     = 1'b1;
                    reg_dst    = RD_R31;
                    mem_to_reg = WD_PC;
                end
                if (instr[I_JR]) begin
                    npc_op = NPC_JR;
                    pc_we  = 1'b1;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = instr[I_SW];
                if (dmem_ack) state_d = instr[I_SW] ? ST_FETCH : ST_WB;
            end
            ST_WB: begin
                reg_we     = 1'b1;
                reg_dst    = (instr[I_ADD] | instr[I_SUB]) ? RD_RD : RD_RT;
                mem_to_reg = instr[I_LW] ? WD_MEM : WD_ALU;
                state_d    = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign state = state_q;
    assign trap  = (state_q == ST_TRAP);

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] instret_cnt_q;
    logic        retire;

    assign retire = (state_d == ST_FETCH) &&
                    (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB);

    // Free-running counters, wrapping naturally at 2^32
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (retire) instret_cnt_q <= instret_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized self-checking bench for mc_ctrl against an instruction-level model
module tb_mc_ctrl;

    logic        clk;
    logic        reset_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        imem_ack;
    logic        dmem_ack;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        pc_we;
    logic        ir_we;
    logic        reg_we;
    logic [1:0]  reg_dst;
    logic        alu_src;
    logic [1:0]  mem_to_reg;
    logic        ext_op;
    logic [3:0]  alu_op;
    logic [2:0]  npc_op;
    logic [2:0]  state;
    logic        trap;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Instruction kinds used by the model
    localparam int K_ADD = 0, K_SUB = 1, K_ORI = 2, K_LW = 3, K_SW = 4;
    localparam int K_BEQ = 5, K_LUI = 6, K_ADDIU = 7, K_JAL = 8, K_JR = 9;

    logic [31:0] exp_cycles;
    logic [31:0] exp_instret;

    mc_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .imem_ack    (imem_ack),
        .dmem_ack    (dmem_ack),
        .imem_req    (imem_req),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .pc_we       (pc_we),
        .ir_we       (ir_we),
        .reg_we      (reg_we),
        .reg_dst     (reg_dst),
        .alu_src     (alu_src),
        .mem_to_reg  (mem_to_reg),
        .ext_op      (ext_op),
        .alu_op      (alu_op),
        .npc_op      (npc_op),
        .state       (state),
        .trap        (trap),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference cycle counter: every clock edge seen outside reset
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) exp_cycles <= '0;
        else          exp_cycles <= exp_cycles + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) return (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b001000);
        return (op == 6'b001101) || (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000100) ||
               (op == 6'b001111) || (op == 6'b001001) || (op == 6'b000011);
    endfunction

    task automatic check_counters(input string tag);
`ifdef MC_CTRL_PERF_EN
        check({tag, "_cycle_cnt"}, cycle_cnt, exp_cycles);
        check({tag, "_instret"}, instret_cnt, exp_instret);
`else
        check({tag, "_cycle_cnt_tied"}, cycle_cnt, 32'd0);
        check({tag, "_instret_tied"}, instret_cnt, 32'd0);
`endif
    endtask

    // Applies reset at a falling edge and checks the idle outputs before any clock edge
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        check({tag, "_rst_state"}, 32'(state), 32'd0);
        check({tag, "_rst_imem_req"}, 32'(imem_req), 32'd1);
        check({tag, "_rst_others"},
              {dmem_req, dmem_we, pc_we, ir_we, reg_we, alu_src, ext_op, trap,
               reg_dst, mem_to_reg, alu_op, npc_op}, 32'd0);
        check({tag, "_rst_cycle_cnt"}, cycle_cnt, 32'd0);
        check({tag, "_rst_instret"}, instret_cnt, 32'd0);
        exp_instret = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Runs one instruction from FETCH back to FETCH and compares the tallies with the model
    task automatic run_instr(input int kind, input bit z, input int iw, input int dw);
        int cyc, wi, wd, n_pc, n_reg, n_ir, n_dreq, n_dwe, e_cyc, e_pc, e_reg;
        bit left, has_mem, has_wb;
        logic       x_src, x_ext;
        logic [3:0] x_alu, e_alu;
        logic [2:0] x_npc, e_npc;
        logic [1:0] w_dst, w_m2r, e_dst, e_m2r;
        logic [5:0] rf;
        cyc = 0; wi = 0; wd = 0; n_pc = 0; n_reg = 0; n_ir = 0; n_dreq = 0; n_dwe = 0;
        left = 0; x_src = 0; x_ext = 0; x_alu = '1; x_npc = '1; w_dst = '1; w_m2r = '1;
        rf = 6'($urandom);
        case (kind)
            K_ADD:   begin opcode = 6'b000000; funct = 6'b100000; end
            K_SUB:   begin opcode = 6'b000000; funct = 6'b100010; end
            K_JR:    begin opcode = 6'b000000; funct = 6'b001000; end
            K_ORI:   begin opcode = 6'b001101; funct = rf; end
            K_LW:    begin opcode = 6'b100011; funct = rf; end
            K_SW:    begin opcode = 6'b101011; funct = rf; end
            K_BEQ:   begin opcode = 6'b000100; funct = rf; end
            K_LUI:   begin opcode = 6'b001111; funct = rf; end
            K_ADDIU: begin opcode = 6'b001001; funct = rf; end
            default: begin opcode = 6'b000011; funct = rf; end
        endcase
        zero = z;
        while (cyc < 60) begin
            imem_ack = imem_req ? (wi == iw) : 1'($urandom);
            dmem_ack = dmem_req ? (wd == dw) : 1'($urandom);
            #1;
            if (state == 3'd2) begin
                x_src = alu_src; x_ext = ext_op; x_alu = alu_op; x_npc = npc_op;
            end
            if (pc_we) n_pc++;
            if (ir_we) n_ir++;
            if (reg_we) begin n_reg++; w_dst = reg_dst; w_m2r = mem_to_reg; end
            if (dmem_req) n_dreq++;
            if (dmem_we) n_dwe++;
            if (imem_req) wi++;
            if (dmem_req) wd++;
            cyc++;
            @(negedge clk);
            if (state != 3'd0) left = 1;
            else if (left) break;
        end
        has_mem = (kind == K_LW) || (kind == K_SW);
        has_wb  = (kind == K_ADD) || (kind == K_SUB) || (kind == K_ORI) || (kind == K_LUI) ||
                  (kind == K_ADDIU) || (kind == K_LW);
        e_cyc = 3 + iw + (has_mem ? 1 + dw : 0) + (has_wb ? 1 : 0);
        e_pc  = 1 + ((kind == K_JAL || kind == K_JR || (kind == K_BEQ && z)) ? 1 : 0);
        e_reg = (has_wb || kind == K_JAL) ? 1 : 0;
        e_alu = (kind == K_SUB || kind == K_BEQ) ? 4'b0001 :
                (kind == K_ORI) ? 4'b0010 : (kind == K_LUI) ? 4'b0100 : 4'b0000;
        e_npc = (kind == K_BEQ) ? 3'b001 : (kind == K_JAL) ? 3'b010 : (kind == K_JR) ? 3'b011 : 3'b000;
        e_dst = (kind == K_ADD || kind == K_SUB) ? 2'b01 : (kind == K_JAL) ? 2'b10 : 2'b00;
        e_m2r = (kind == K_LW) ? 2'b01 : (kind == K_JAL) ? 2'b10 : 2'b00;
        if (cyc < 60) exp_instret = exp_instret + 32'd1;
        check($sformatf("k%0d_cycles", kind), cyc, e_cyc);
        check($sformatf("k%0d_pc_we_cnt", kind), n_pc, e_pc);
        check($sformatf("k%0d_ir_we_cnt", kind), n_ir, 1);
        check($sformatf("k%0d_reg_we_cnt", kind), n_reg, e_reg);
        check($sformatf("k%0d_dmem_req_cyc", kind), n_dreq, has_mem ? 1 + dw : 0);
        check($sformatf("k%0d_dmem_we_cyc", kind), n_dwe, (kind == K_SW) ? 1 + dw : 0);
        check($sformatf("k%0d_alu_src", kind), 32'(x_src),
              32'(kind == K_ORI || kind == K_LW || kind == K_SW || kind == K_LUI || kind == K_ADDIU));
        check($sformatf("k%0d_ext_op", kind), 32'(x_ext),
              32'(kind == K_LW || kind == K_SW || kind == K_ADDIU));
        check($sformatf("k%0d_alu_op", kind), 32'(x_alu), 32'(e_alu));
        check($sformatf("k%0d_npc_op", kind), 32'(x_npc), 32'(e_npc));
        if (e_reg == 1) begin
            check($sformatf("k%0d_reg_dst", kind), 32'(w_dst), 32'(e_dst));
            check($sformatf("k%0d_mem_to_reg", kind), 32'(w_m2r), 32'(e_m2r));
        end
        check($sformatf("k%0d_trap", kind), 32'(trap), 32'd0);
        check_counters($sformatf("k%0d", kind));
    endtask

    // Feeds an illegal encoding and expects TRAP to hold with everything quiet
    task automatic run_trap(input logic [5:0] op, input logic [5:0] fn, input int hold);
        int cyc, bad;
        opcode = op; funct = fn; zero = 1'b0;
        cyc = 0; bad = 0;
        while (cyc < 10 && state != 3'd7) begin
            imem_ack = imem_req;
            @(negedge clk);
            cyc++;
        end
        imem_ack = 1'b0;
        check("trap_entry_state", 32'(state), 32'd7);
        for (int i = 0; i < hold; i++) begin
            imem_ack = 1'($urandom);
            dmem_ack = 1'($urandom);
            #1;
            if (trap !== 1'b1 || state !== 3'd7 ||
                {imem_req, dmem_req, dmem_we, pc_we, ir_we, reg_we} !== 6'd0) bad++;
            @(negedge clk);
        end
        check("trap_hold_bad_cycles", bad, 0);
        reset_n = 1'b0;
        #1;
        check("trap_async_exit_state", 32'(state), 32'd0);
        check("trap_async_exit_trap", 32'(trap), 32'd0);
        exp_instret = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [5:0] rop, rfn;
        int         cyc, bad;
        reset_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        exp_instret = '0;
        do_reset("init");

        run_instr(K_ADD, 1'b0, 0, 0);
        run_instr(K_LW, 1'b0, 0, 3);
        run_instr(K_BEQ, 1'b0, 0, 0);
        run_instr(K_BEQ, 1'b1, 0, 0);
        run_instr(K_JAL, 1'b0, 0, 0);
        run_instr(K_SW, 1'b0, 1, 0);
        run_instr(K_JR, 1'b0, 0, 0);
        for (int i = 0; i < 60; i++)
            run_instr(int'($urandom_range(0, 9)), 1'($urandom), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));

        run_trap(6'b111111, 6'($urandom), 20);
        for (int i = 0; i < 4; i++) begin
            do begin
                rop = 6'($urandom);
                rfn = 6'($urandom);
            end while (is_legal(rop, rfn));
            run_trap(rop, rfn, 5);
        end

        // Reset asserted while an sw waits in MEM
        opcode = 6'b101011; funct = '0; dmem_ack = 1'b0;
        cyc = 0;
        while (cyc < 20 && dmem_req !== 1'b1) begin
            imem_ack = imem_req;
            #1;
            if (dmem_req !== 1'b1) @(negedge clk);
            cyc++;
        end
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("midmem_dmem_req_before", 32'(dmem_req), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midmem_dmem_req_async", 32'(dmem_req), 32'd0);
        check("midmem_state_async", 32'(state), 32'd0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (reg_we !== 1'b0 || dmem_req !== 1'b0) bad++;
        end
        check("midmem_no_reg_we", bad, 0);
        exp_instret = '0;
        reset_n = 1'b1;
        run_instr(K_ORI, 1'b0, 0, 0);

`ifdef MC_CTRL_PERF_EN
        @(negedge clk);
        dut.cycle_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        check("wrap_cycle_max", cycle_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        check("wrap_cycle_zero", cycle_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
